mioc_flop_bank: RTL and testbench

MIOC_FLOP_BANK -- requirements
Module: mioc_flop_bank

---
 rtl/mioc_flop_bank_pkg.sv | 29 ++
 rtl/mioc_flop_cell.sv | 50 +++++
 rtl/mioc_flop_bank.sv | 41 ++++
 tb/tb_mioc_flop_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mioc_flop_bank_pkg.sv
// Shared MIOC definitions: strobe edge polarity encodings and the per-channel
// update priority used by the flop bank and its bench.
package mioc_flop_bank_pkg;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_CLR  = 2'd1,
    ACT_SET  = 2'd2,
    ACT_LOAD = 2'd3
  } flop_action_e;

  // Clear beats set, set beats a strobe edge, otherwise the channel holds.
  function automatic flop_action_e select_action(
    input logic clr,
    input logic set,
    input logic strobe_edge
  );
    if (clr)              return ACT_CLR;
    else if (set)         return ACT_SET;
    else if (strobe_edge) return ACT_LOAD;
    else                  return ACT_HOLD;
  endfunction

endpackage

// File: rtl/mioc_flop_cell.sv
// One flop channel: strobe edge detector, clr/set/edge priority mux,
// the q register and its one-cycle change pulse.
module mioc_flop_cell
  import mioc_flop_bank_pkg::*;
#(
  parameter logic RST_BIT  = 1'b0,
  parameter int   EDGE_POL = EDGE_FALL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic set,
  input  logic stb,
  input  logic d,
  input  logic tgl,
  output logic q,
  output logic chg
);

  logic         stb_q;
  logic         strobe_edge;
  logic         q_next;
  flop_action_e action;

  assign strobe_edge = (EDGE_POL == EDGE_RISE) ? (stb & ~stb_q) : (~stb & stb_q);
  assign action      = select_action(clr, set, strobe_edge);

  always_comb begin
    q_next = q;
    case (action)
      ACT_CLR:  q_next = 1'b0;
      ACT_SET:  q_next = 1'b1;
      ACT_LOAD: q_next = tgl ? ~q : d;
      default:  q_next = q;
    endcase
  end

  // stb_q tracks stb every cycle, so an edge masked by clr/set or reset is lost.
  always_ff @(posedge clk) begin
    stb_q <= stb;
    if (rst) begin
      q   <= RST_BIT;
      chg <= 1'b0;
    end else begin
      q   <= q_next;
      chg <= q_next ^ q;
    end
  end

endmodule

// File: rtl/mioc_flop_bank.sv
// Bank of WIDTH independent strobe-loaded flops with clear, set and toggle;
// all state lives in the per-channel cells.
module mioc_flop_bank
  import mioc_flop_bank_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}},
  parameter int               EDGE_POL = EDGE_FALL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] stb,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] tgl,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] chg
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    mioc_flop_cell #(
      .RST_BIT  (RST_VAL[i]),
      .EDGE_POL (EDGE_POL)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .clr (clr[i]),
      .set (set[i]),
      .stb (stb[i]),
      .d   (d[i]),
      .tgl (tgl[i]),
      .q   (q[i]),
      .chg (chg[i])
    );
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_mioc_flop_bank.sv
// Bench for mioc_flop_bank: a falling-edge and a rising-edge instance driven
// by shared stimulus and checked every cycle against a behavioural model.
module tb_mioc_flop_bank;
  import mioc_flop_bank_pkg::*;

  localparam logic [7:0] RST_A = 8'hA5;
  localparam logic [7:0] RST_B = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] clr, set, stb, d, tgl;
  logic [7:0] q_a, qbar_a, chg_a;
  logic [7:0] q_b, qbar_b, chg_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state: index 0 = falling-edge instance, 1 = rising-edge instance.
  logic [7:0] m_q   [2];
  logic [7:0] m_chg [2];
  logic [7:0] m_prev;
  logic [7:0] m_next;
  logic [7:0] m_rst [2];
  logic       m_hit;
  bit         model_valid = 0;

  always #5 clk = ~clk;

  mioc_flop_bank #(.WIDTH(8), .RST_VAL(RST_A), .EDGE_POL(EDGE_FALL)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .set(set), .stb(stb), .d(d), .tgl(tgl),
    .q(q_a), .qbar(qbar_a), .chg(chg_a)
  );

  mioc_flop_bank #(.WIDTH(8), .RST_VAL(RST_B), .EDGE_POL(EDGE_RISE)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .set(set), .stb(stb), .d(d), .tgl(tgl),
    .q(q_b), .qbar(qbar_b), .chg(chg_b)
  );

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] c, input logic [7:0] s,
                               input logic [7:0] sb, input logic [7:0] dd, input logic [7:0] tg);
    @(negedge clk);
    rst = r; clr = c; set = s; stb = sb; d = dd; tgl = tg;
    @(posedge clk);
    #1;
  endtask

  // Reference model: each channel follows clr > set > strobe edge > hold.
  always @(posedge clk) begin
    m_rst[0] = RST_A;
    m_rst[1] = RST_B;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_hit = (k == 0) ? (m_prev[i] === 1'b1 && stb[i] === 1'b0)
                         : (m_prev[i] === 1'b0 && stb[i] === 1'b1);
        if (rst)         m_next[i] = m_rst[k][i];
        else if (clr[i]) m_next[i] = 1'b0;
        else if (set[i]) m_next[i] = 1'b1;
        else if (m_hit)  m_next[i] = tgl[i] ? ~m_q[k][i] : d[i];
        else             m_next[i] = m_q[k][i];
      end
      m_chg[k] = rst ? 8'h00 : (m_next ^ m_q[k]);
      m_q[k]   = m_next;
    end
    m_prev = stb;
    if (rst) model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model q_a",    q_a,    m_q[0]);
      checkOutput("model qbar_a", qbar_a, ~m_q[0]);
      checkOutput("model chg_a",  chg_a,  m_chg[0]);
      checkOutput("model q_b",    q_b,    m_q[1]);
      checkOutput("model qbar_b", qbar_b, ~m_q[1]);
      checkOutput("model chg_b",  chg_b,  m_chg[1]);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; clr = 8'h00; set = 8'h00; stb = 8'hFF; d = 8'h00; tgl = 8'h00;

    // Two reset cycles with strobe high, then a static post-reset cycle.
    applyStimulus(1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
    checkOutput("reset q_a",    q_a,    8'hA5);
    checkOutput("reset qbar_a", qbar_a, 8'h5A);
    checkOutput("reset chg_a",  chg_a,  8'h00);
    checkOutput("reset q_b",    q_b,    8'h00);
    applyStimulus(0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
    checkOutput("post reset q_a",   q_a,   8'hA5);
    checkOutput("post reset chg_a", chg_a, 8'h00);
    checkOutput("post reset q_b",   q_b,   8'h00);

    // Falling strobe on every channel loads 3C.
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00);
    checkOutput("load q_a",   q_a,   8'h3C);
    checkOutput("load chg_a", chg_a, 8'h99);
    checkOutput("load q_b",   q_b,   8'h00);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00);
    checkOutput("load chg_a clears", chg_a, 8'h00);
    checkOutput("load q_a holds",    q_a,   8'h3C);

    // Toggle channel 0 with four falling edges.
    for (int j = 0; j < 4; j++) begin
      applyStimulus(0, 8'h00, 8'h00, 8'h01, 8'h3C, 8'h01);
      checkOutput("toggle rise chg_a", chg_a, 8'h00);
      applyStimulus(0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h01);
      checkOutput("toggle q_a[0]", q_a & 8'h01, (j % 2 == 0) ? 8'h01 : 8'h00);
      checkOutput("toggle chg_a",  chg_a, 8'h01);
    end

    // Channel 3: clr, set and a falling edge together; clear wins, nothing deferred.
    applyStimulus(0, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00);
    checkOutput("ch3 pre q_a", q_a, 8'h3C);
    applyStimulus(0, 8'h08, 8'h08, 8'h00, 8'h08, 8'h00);
    checkOutput("ch3 clr q_a",   q_a,   8'h34);
    checkOutput("ch3 clr chg_a", chg_a, 8'h08);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00);
    checkOutput("ch3 release q_a",   q_a,   8'h34);
    checkOutput("ch3 release chg_a", chg_a, 8'h00);

    // Rising-edge instance, channel 5.
    applyStimulus(0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("clear all q_a", q_a, 8'h00);
    checkOutput("clear all q_b", q_b, 8'h00);
    applyStimulus(0, 8'h00, 8'h00, 8'h20, 8'h20, 8'h00);
    checkOutput("rise load q_b",   q_b,   8'h20);
    checkOutput("rise load chg_b", chg_b, 8'h20);
    checkOutput("rise ignored q_a", q_a,  8'h00);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("fall ignored q_b",   q_b,   8'h20);
    checkOutput("fall ignored chg_b", chg_b, 8'h00);
    applyStimulus(0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
    checkOutput("set on one q_b",   q_b,   8'h20);
    checkOutput("set on one chg_b", chg_b, 8'h00);
    checkOutput("set on zero chg_a", chg_a, 8'h20);

    // Reset coincident with a falling edge carrying FF.
    applyStimulus(0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
    checkOutput("pre reset q_b", q_b, 8'h00);
    applyStimulus(1, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
    checkOutput("edge in reset q_a",   q_a,   8'hA5);
    checkOutput("edge in reset chg_a", chg_a, 8'h00);
    checkOutput("edge in reset q_b",   q_b,   8'h00);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
    checkOutput("after reset q_a",   q_a,   8'hA5);
    checkOutput("after reset chg_a", chg_a, 8'h00);
    checkOutput("after reset q_b",   q_b,   8'h00);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    8'($urandom & $urandom & $urandom),
                    8'($urandom & $urandom & $urandom),
                    8'($urandom), 8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
